prirv32_mem_arb: RTL and testbench
==================================

// Module: prirv32_mem_arb
// PURPOSE
//  Shares the core's single memory port between instruction fetch (IF) and the load/store
//  path fed by the EXU's lb/lh/lw/lbu/lhu and sb/sh/sw decodes. Arbitrates, handles one
//  transaction at a time, generates byte strobes, aligns/extends load data, flags
//  misalignment and bus timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles in BUSY without mem_ready before error; 0 disables timeout
// PORTS
//  clk_in           in   1   core clock
//  rst_n            in   1   synchronous, active-low reset
//  if_req_valid     in   1   fetch request
//  if_req_addr      in   32  fetch byte address
//  if_req_ready     out  1   fetch request accepted this cycle
//  if_rsp_valid     out  1   fetch response pulse
//  if_rsp_rdata     out  32  instruction word
//  if_rsp_err       out  1   misaligned or timeout
//  ls_req_valid     in   1   load/store request
//  ls_req_we        in   1   1=store, 0=load
//  ls_req_size      in   2   00 byte, 01 half, 10 word, 11 illegal
//  ls_req_unsigned  in   1   zero-extend load (lbu/lhu)
//  ls_req_addr      in   32  byte address
//  ls_req_wdata     in   32  store data, LSB-aligned
//  ls_req_ready     out  1   ls request accepted this cycle
//  ls_rsp_valid     out  1   ls response pulse
//  ls_rsp_rdata     out  32  extended load data; 0 for stores/errors
//  ls_rsp_err       out  1   misaligned, illegal size or timeout
//  mem_valid        out  1   memory request, held until mem_ready
//  mem_addr         out  32  word address ({addr[31:2],2'b00})
//  mem_wdata        out  32  lane-replicated store data
//  mem_wstrb        out  4   byte enables; 0000 = read
//  mem_ready        in   1   memory done; mem_rdata valid same cycle
//  mem_rdata        in   32  read word
// BEHAVIOUR
//  - Reset: state IDLE, rr pointer=LS, all outputs 0. Reset mid-transaction aborts it; no response.
//  - FSM IDLE -> BUSY (legal request accepted) -> RESP (mem_ready or timeout) -> IDLE.
//    Illegal request: IDLE -> RESP directly, err=1, no mem access.
//  - ready is combinational, asserted only in IDLE for the granted requester; accept = valid&ready.
//  - Grant: only one valid -> it wins. Both valid -> rr pointer side wins; pointer then flips to
//    the loser. First conflict after reset goes to LS.
//  - BUSY: mem_valid=1, mem_addr/wdata/wstrb registered at accept, stable until mem_ready.
//    mem_ready sampled only while mem_valid=1; rdata captured that cycle.
//  - RESP: exactly one cycle, rsp_valid of owner=1; no response back-pressure. Latency
//    accept->rsp_valid = wait cycles + 2 (mem_ready in first BUSY cycle -> rsp 2 cycles after accept).
//  - Misaligned: fetch addr[1:0]!=0; half addr[0]=1; word addr[1:0]!=0; size 11 -> err=1, rdata=0.
//  - Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111.
//    wdata: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word as is.
//  - Load: select lane by addr[1:0]; byte/half sign-extend unless unsigned; word unchanged.
//  - Timeout: counter clears on entry to BUSY; reaching TIMEOUT_CYCLES without mem_ready drops
//    mem_valid, RESP with err=1, rdata=0. Counter saturates; idle when TIMEOUT_CYCLES=0.
//  - Requests arriving in BUSY/RESP are not accepted (ready=0); requester holds valid.
// STRUCTURE
//  - prirv32_pkg: size encodings (SZ_B/SZ_H/SZ_W), FSM state enum, owner enum (OWN_IF/OWN_LS).
//  - Sub-module prirv32_load_align: combinational lane select + sign/zero extension.
//  - Top: FSM, rr pointer, request/attribute registers, strobe/wdata gen, timeout counter.
// TESTING
//  - Reset: rst_n=0 two cycles -> all outputs 0, state IDLE; rst_n=0 in BUSY -> mem_valid 0 next cycle, no rsp.
//  - Fetch addr 0x100, mem_ready first BUSY cycle, rdata 0x00000013 -> if_rsp_valid 2 cycles after accept, rdata 0x13, err 0.
//  - Both valid every cycle -> grants LS,IF,LS,IF; no starvation over 8 transactions.
//  - sb addr 0x203 wdata 0xAB -> mem_addr 0x200, wstrb 1000, wdata 0xABABABAB; sh 0x202 -> wstrb 1100.
//  - lb 0x201, rdata 0x0000_80FF -> 0xFFFFFF80; lbu -> 0x80; lh 0x202 rdata 0x8001_0000 -> 0xFFFF8001.
//  - lw 0x206 -> ls_rsp_err=1 one cycle after accept, mem_valid never 1; size 11 same.
//  - TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid drops, ls_rsp_err=1, rdata 0, IDLE after.

Source files
------------

// File: rtl/prirv32_pkg.sv
// Shared encodings and helpers for the prirv32 memory arbiter: access sizes,
// FSM states, port owners and the byte-lane helper functions.
package prirv32_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    // Illegal size (11) is reported through the same error path as misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 1'b0;
            SZ_H:    return off[0];
            SZ_W:    return off != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [3:0] gen_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_B:    return 4'b0001 << off;
            SZ_H:    return 4'b0011 << {off[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] gen_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SZ_B:    return {4{wdata[7:0]}};
            SZ_H:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/prirv32_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the memory
// word and sign- or zero-extends it to 32 bits.
module prirv32_load_align
    import prirv32_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // NOTE: every output of a combinational block gets a value on every path,
    // otherwise synthesis infers a latch.
    always_comb begin
        byte_lane = rdata_i[7:0];
        case (off_i)
            2'd1:    byte_lane = rdata_i[15:8];
            2'd2:    byte_lane = rdata_i[23:16];
            2'd3:    byte_lane = rdata_i[31:24];
            default: byte_lane = rdata_i[7:0];
        endcase
        half_lane = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (size_i)
            SZ_B:    data_o = {{24{byte_lane[7] & ~unsigned_i}}, byte_lane};
            SZ_H:    data_o = {{16{half_lane[15] & ~unsigned_i}}, half_lane};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/prirv32_mem_arb.sv
// Arbiter sharing the single memory port between instruction fetch and the
// load/store path: one transaction at a time, round-robin on conflicts.
module prirv32_mem_arb
    import prirv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_in,
    input  logic        rst_n,

    input  logic        if_req_valid,
    input  logic [31:0] if_req_addr,
    output logic        if_req_ready,
    output logic        if_rsp_valid,
    output logic [31:0] if_rsp_rdata,
    output logic        if_rsp_err,

    input  logic        ls_req_valid,
    input  logic        ls_req_we,
    input  logic [1:0]  ls_req_size,
    input  logic        ls_req_unsigned,
    input  logic [31:0] ls_req_addr,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_req_ready,
    output logic        ls_rsp_valid,
    output logic [31:0] ls_rsp_rdata,
    output logic        ls_rsp_err,

    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    // The counter only needs to reach TIMEOUT_CYCLES-1 before the timeout fires.
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_t        state_q, state_d;
    owner_t        rr_q, rr_d;
    owner_t        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [29:0]   addr_q;
    logic [1:0]    off_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic          we_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   wdata_q;

    owner_t        gnt;
    logic          accept;
    logic          conflict;
    logic [31:0]   req_addr;
    logic [1:0]    req_size;
    logic          req_we;
    logic          req_uns;
    logic          req_bad;
    logic          timeout_hit;
    logic [31:0]   load_data;

    assign conflict = if_req_valid && ls_req_valid;

    always_comb begin
        gnt = OWN_LS;
        if (conflict) begin
            gnt = rr_q;
        end else if (if_req_valid) begin
            gnt = OWN_IF;
        end
    end

    // Ready is held low during reset so every output is quiet while rst_n=0.
    assign if_req_ready = rst_n && (state_q == ST_IDLE) && if_req_valid && (gnt == OWN_IF);
    assign ls_req_ready = rst_n && (state_q == ST_IDLE) && ls_req_valid && (gnt == OWN_LS);
    assign accept       = if_req_ready || ls_req_ready;

    // Fetches are treated as unsigned word reads so the aligner passes them through.
    assign req_addr = (gnt == OWN_IF) ? if_req_addr : ls_req_addr;
    assign req_size = (gnt == OWN_IF) ? SZ_W : ls_req_size;
    assign req_we   = (gnt == OWN_LS) && ls_req_we;
    assign req_uns  = (gnt == OWN_IF) || ls_req_unsigned;
    assign req_bad  = is_misaligned(req_size, req_addr[1:0]);

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (32'(cnt_q) == TIMEOUT_CYCLES - 32'd1);

    prirv32_load_align u_load_align (
        .rdata_i    (mem_rdata),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .data_o     (load_data)
    );

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    owner_d = gnt;
                    cnt_d   = '0;
                    rdata_d = '0;
                    if (conflict) begin
                        rr_d = (gnt == OWN_IF) ? OWN_LS : OWN_IF;
                    end
                    if (req_bad) begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        err_d   = 1'b0;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                    err_d   = 1'b0;
                    rdata_d = we_q ? '0 : load_data;
                end else if (timeout_hit) begin
                    state_d = ST_RESP;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (cnt_q != '1)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every register samples the pre-edge values regardless of block order.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= OWN_LS;
            owner_q <= OWN_LS;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: request attributes are only observed while BUSY/RESP and are
    // reloaded on every accept; they are reset anyway to keep X out of simulation.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            addr_q  <= '0;
            off_q   <= '0;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            wstrb_q <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= req_addr[31:2];
            off_q   <= req_addr[1:0];
            size_q  <= req_size;
            uns_q   <= req_uns;
            we_q    <= req_we;
            wstrb_q <= req_we ? gen_strb(req_size, req_addr[1:0]) : 4'b0000;
            wdata_q <= gen_wdata(req_size, ls_req_wdata);
        end
    end

    assign mem_valid = (state_q == ST_BUSY);
    assign mem_addr  = mem_valid ? {addr_q, 2'b00} : '0;
    assign mem_wdata = mem_valid ? wdata_q : '0;
    assign mem_wstrb = mem_valid ? wstrb_q : '0;

    assign if_rsp_valid = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign ls_rsp_valid = (state_q == ST_RESP) && (owner_q == OWN_LS);
    assign if_rsp_rdata = if_rsp_valid ? rdata_q : '0;
    assign ls_rsp_rdata = ls_rsp_valid ? rdata_q : '0;
    assign if_rsp_err   = if_rsp_valid && err_q;
    assign ls_rsp_err   = ls_rsp_valid && err_q;

endmodule

// File: tb/tb_prirv32_mem_arb.sv
// Self-checking bench for prirv32_mem_arb: directed corner cases followed by
// randomized fetch/load/store traffic scored against a behavioural model.
module tb_prirv32_mem_arb;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        if_req_valid;
    logic [31:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic        ls_req_we;
    logic [1:0]  ls_req_size;
    logic        ls_req_unsigned;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic        ls_req_ready;
    logic        ls_rsp_valid;
    logic [31:0] ls_rsp_rdata;
    logic        ls_rsp_err;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    always #5 clk_in = ~clk_in;

    prirv32_mem_arb #(.TIMEOUT_CYCLES(4)) dut (
        .clk_in          (clk_in),
        .rst_n           (rst_n),
        .if_req_valid    (if_req_valid),
        .if_req_addr     (if_req_addr),
        .if_req_ready    (if_req_ready),
        .if_rsp_valid    (if_rsp_valid),
        .if_rsp_rdata    (if_rsp_rdata),
        .if_rsp_err      (if_rsp_err),
        .ls_req_valid    (ls_req_valid),
        .ls_req_we       (ls_req_we),
        .ls_req_size     (ls_req_size),
        .ls_req_unsigned (ls_req_unsigned),
        .ls_req_addr     (ls_req_addr),
        .ls_req_wdata    (ls_req_wdata),
        .ls_req_ready    (ls_req_ready),
        .ls_rsp_valid    (ls_rsp_valid),
        .ls_rsp_rdata    (ls_rsp_rdata),
        .ls_rsp_err      (ls_rsp_err),
        .mem_valid       (mem_valid),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_wstrb       (mem_wstrb),
        .mem_ready       (mem_ready),
        .mem_rdata       (mem_rdata)
    );

    typedef struct packed {
        logic        is_if;
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    int   checks   = 0;
    int   failures = 0;
    bit   ptr_if   = 1'b0;   // side that wins the next conflict (0 = LS)
    bit   if_pend  = 1'b0;
    bit   ls_pend  = 1'b0;
    req_t if_r;
    req_t ls_r;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic req_t mk_if(input logic [31:0] addr);
        req_t r;
        r       = '0;
        r.is_if = 1'b1;
        r.size  = 2'b10;
        r.addr  = addr;
        return r;
    endfunction

    function automatic req_t mk_ls(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        req_t r;
        r.is_if = 1'b0;
        r.we    = we;
        r.size  = size;
        r.uns   = uns;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    function automatic req_t rand_if();
        logic [31:0] a;
        a = $urandom;
        if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
        return mk_if(a);
    endfunction

    function automatic req_t rand_ls();
        logic [1:0] sz;
        sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        return mk_ls(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), $urandom, $urandom);
    endfunction

    task automatic drive(input req_t r);
        if (r.is_if) begin
            if_req_valid = 1'b1;
            if_req_addr  = r.addr;
        end else begin
            ls_req_valid    = 1'b1;
            ls_req_we       = r.we;
            ls_req_size     = r.size;
            ls_req_unsigned = r.uns;
            ls_req_addr     = r.addr;
            ls_req_wdata    = r.wdata;
        end
    endtask

    // Expected bus/response values derived from byte counts and lane arithmetic.
    function automatic void model(input req_t r, input logic [31:0] rd, output logic err,
                                  output logic [3:0] strb, output logic [31:0] wd,
                                  output logic [31:0] rdata);
        int     off;
        int     nb;
        longint v;
        off = int'(r.addr[1:0]);
        if (r.is_if)              nb = 4;
        else if (r.size == 2'b00) nb = 1;
        else if (r.size == 2'b01) nb = 2;
        else if (r.size == 2'b10) nb = 4;
        else                      nb = 0;
        err   = (nb == 0) || ((off % nb) != 0);
        strb  = '0;
        wd    = '0;
        rdata = '0;
        if (!err) begin
            for (int i = 0; i < 4; i++) begin
                if (!r.is_if && r.we && i >= off && i < off + nb) strb[i] = 1'b1;
                wd[8*i +: 8] = r.wdata[8*(i % nb) +: 8];
            end
            if (r.is_if) begin
                rdata = rd;
            end else if (!r.we) begin
                v = (longint'(rd) >> (8 * off)) & ((64'd1 << (8 * nb)) - 1);
                if (!r.uns && nb < 4 && v >= longint'(64'd1 << (8 * nb - 1)))
                    v = v - longint'(64'd1 << (8 * nb));
                rdata = v[31:0];
            end
        end
    endfunction

    // Called in IDLE with the request already driven; plays the memory side
    // and checks the whole transaction up to the cycle after the response.
    task automatic do_txn(input req_t r, input int waits, input logic [31:0] rd, input bit hang,
                          output logic [31:0] o_addr, output logic [3:0] o_strb,
                          output logic [31:0] o_wdata, output logic [31:0] o_rdata,
                          output logic o_err);
        logic        e_err;
        logic [3:0]  e_strb;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        int          n;
        model(r, rd, e_err, e_strb, e_wd, e_rd);
        if (hang) begin
            e_err = 1'b1;
            e_rd  = '0;
        end
        o_addr  = '0;
        o_strb  = '0;
        o_wdata = '0;
        #1;
        check("grant", 32'(r.is_if ? if_req_ready : ls_req_ready), 32'd1);
        check("no_grant_other", 32'(r.is_if ? ls_req_ready : if_req_ready), 32'd0);
        tick();
        if (r.is_if) if_req_valid = 1'b0;
        else         ls_req_valid = 1'b0;
        n = 0;
        while (mem_valid === 1'b1 && n < 40) begin
            if (n == 0) begin
                o_addr  = mem_addr;
                o_strb  = mem_wstrb;
                o_wdata = mem_wdata;
            end
            check("mem_addr", mem_addr, {r.addr[31:2], 2'b00});
            check("mem_wstrb", 32'(mem_wstrb), 32'(e_strb));
            if (!r.is_if && r.we) check("mem_wdata", mem_wdata, e_wd);
            check("busy_ready", 32'(if_req_ready | ls_req_ready), 32'd0);
            check("busy_rsp", 32'(if_rsp_valid | ls_rsp_valid), 32'd0);
            if (!hang && n == waits) begin
                mem_ready = 1'b1;
                mem_rdata = rd;
            end else begin
                mem_rdata = $urandom;
            end
            tick();
            mem_ready = 1'b0;
            n++;
        end
        if (hang)       check("timeout_cycles", 32'(n == 4 || n == 5), 32'd1);
        else if (e_err) check("busy_cycles", n, 0);
        else            check("busy_cycles", n, waits + 1);
        check("rsp_valid", 32'(r.is_if ? if_rsp_valid : ls_rsp_valid), 32'd1);
        check("rsp_other", 32'(r.is_if ? ls_rsp_valid : if_rsp_valid), 32'd0);
        o_rdata = r.is_if ? if_rsp_rdata : ls_rsp_rdata;
        o_err   = r.is_if ? if_rsp_err : ls_rsp_err;
        check("rsp_rdata", o_rdata, e_rd);
        check("rsp_err", 32'(o_err), 32'(e_err));
        tick();
        check("rsp_pulse", 32'(if_rsp_valid | ls_rsp_valid), 32'd0);
    endtask

    task automatic arb_round(input bit force_both);
        bit          w_if;
        logic [31:0] a, wd, rdo;
        logic [3:0]  s;
        logic        e;
        if (!if_pend && (force_both || $urandom_range(0, 1) == 1)) begin
            if_r    = rand_if();
            if_pend = 1'b1;
        end
        if (!ls_pend && (force_both || $urandom_range(0, 1) == 1)) begin
            ls_r    = rand_ls();
            ls_pend = 1'b1;
        end
        if (!if_pend && !ls_pend) begin
            ls_r    = rand_ls();
            ls_pend = 1'b1;
        end
        if (if_pend) drive(if_r);
        if (ls_pend) drive(ls_r);
        if (if_pend && ls_pend) begin
            w_if   = ptr_if;
            ptr_if = !ptr_if;
        end else begin
            w_if = if_pend;
        end
        do_txn(w_if ? if_r : ls_r, $urandom_range(0, 2), $urandom, 1'b0, a, s, wd, rdo, e);
        if (w_if) if_pend = 1'b0;
        else      ls_pend = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        req_t        r;
        logic [31:0] a, wd, rdo;
        logic [3:0]  s;
        logic        e;

        rst_n           = 1'b0;
        if_req_valid    = 1'b0;
        if_req_addr     = '0;
        ls_req_valid    = 1'b0;
        ls_req_we       = 1'b0;
        ls_req_size     = 2'b00;
        ls_req_unsigned = 1'b0;
        ls_req_addr     = '0;
        ls_req_wdata    = '0;
        mem_ready       = 1'b0;
        mem_rdata       = '0;
        tick();
        tick();
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
        check("rst_ready", 32'(if_req_ready | ls_req_ready), 32'd0);
        check("rst_rsp_valid", 32'(if_rsp_valid | ls_rsp_valid), 32'd0);
        check("rst_rsp_rdata", if_rsp_rdata | ls_rsp_rdata, 32'd0);
        check("rst_rsp_err", 32'(if_rsp_err | ls_rsp_err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Fetch with zero wait states.
        r = mk_if(32'h0000_0100);
        drive(r);
        do_txn(r, 0, 32'h0000_0013, 1'b0, a, s, wd, rdo, e);
        check("fetch_addr", a, 32'h0000_0100);
        check("fetch_rdata", rdo, 32'h0000_0013);
        check("fetch_err", 32'(e), 32'd0);

        // Byte and half stores.
        r = mk_ls(1'b1, 2'b00, 1'b0, 32'h0000_0203, 32'h0000_00AB);
        drive(r);
        do_txn(r, 1, $urandom, 1'b0, a, s, wd, rdo, e);
        check("sb_addr", a, 32'h0000_0200);
        check("sb_wstrb", 32'(s), 32'h8);
        check("sb_wdata", wd, 32'hABAB_ABAB);
        check("sb_rdata", rdo, 32'd0);
        r = mk_ls(1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_1234);
        drive(r);
        do_txn(r, 2, $urandom, 1'b0, a, s, wd, rdo, e);
        check("sh_wstrb", 32'(s), 32'hC);

        // Loads with sign/zero extension.
        r = mk_ls(1'b0, 2'b00, 1'b0, 32'h0000_0201, 32'd0);
        drive(r);
        do_txn(r, 0, 32'h0000_80FF, 1'b0, a, s, wd, rdo, e);
        check("lb_rdata", rdo, 32'hFFFF_FF80);
        check("lb_wstrb", 32'(s), 32'd0);
        r = mk_ls(1'b0, 2'b00, 1'b1, 32'h0000_0201, 32'd0);
        drive(r);
        do_txn(r, 1, 32'h0000_80FF, 1'b0, a, s, wd, rdo, e);
        check("lbu_rdata", rdo, 32'h0000_0080);
        r = mk_ls(1'b0, 2'b01, 1'b0, 32'h0000_0202, 32'd0);
        drive(r);
        do_txn(r, 0, 32'h8001_0000, 1'b0, a, s, wd, rdo, e);
        check("lh_rdata", rdo, 32'hFFFF_8001);

        // Misaligned / illegal requests never reach memory.
        r = mk_ls(1'b0, 2'b10, 1'b0, 32'h0000_0206, 32'd0);
        drive(r);
        do_txn(r, 0, 32'd0, 1'b0, a, s, wd, rdo, e);
        check("lw_mis_err", 32'(e), 32'd1);
        check("lw_mis_rdata", rdo, 32'd0);
        r = mk_ls(1'b1, 2'b11, 1'b0, 32'h0000_0200, 32'h5555_5555);
        drive(r);
        do_txn(r, 0, 32'd0, 1'b0, a, s, wd, rdo, e);
        check("size11_err", 32'(e), 32'd1);
        r = mk_if(32'h0000_0102);
        drive(r);
        do_txn(r, 0, 32'd0, 1'b0, a, s, wd, rdo, e);
        check("fetch_mis_err", 32'(e), 32'd1);

        // Bus timeout with mem_ready never asserted.
        r = mk_ls(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'd0);
        drive(r);
        do_txn(r, 0, 32'd0, 1'b1, a, s, wd, rdo, e);
        check("timeout_err", 32'(e), 32'd1);
        check("timeout_rdata", rdo, 32'd0);

        // Reset in the middle of a transaction aborts it without a response.
        r = mk_if(32'h0000_0400);
        drive(r);
        #1;
        tick();
        if_req_valid = 1'b0;
        check("abort_busy", 32'(mem_valid), 32'd1);
        rst_n = 1'b0;
        tick();
        check("abort_mem_valid", 32'(mem_valid), 32'd0);
        check("abort_rsp", 32'(if_rsp_valid | ls_rsp_valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check("abort_rsp_after", 32'(if_rsp_valid | ls_rsp_valid | mem_valid), 32'd0);
        tick();
        check("abort_quiet", 32'(if_rsp_valid | ls_rsp_valid | mem_valid), 32'd0);
        ptr_if = 1'b0;

        // Both requesters valid every cycle: strict alternation starting with LS.
        for (int k = 0; k < 8; k++) arb_round(1'b1);

        // Randomized mixed traffic.
        for (int k = 0; k < 120; k++) arb_round(1'b0);
        while (if_pend || ls_pend) arb_round(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
